split_2o: RTL
=============

# split_2o

Channel-wise stream splitter that sits directly upstream of the two-input merge stage in the CNN datapath. It takes one valid-qualified pixel stream carrying a D×D×(C_1+C_2) feature map, channel-major. It routes the first D·D·C_1 pixels to output 1 and the remaining D·D·C_2 pixels to output 2, so each branch can be processed independently before re-merging. A broadcast mode instead duplicates every pixel to both outputs, for fork points where both branches consume the same tensor.

## Interface
- `D`, 220: spatial width/height of the feature map.
- `C_1`, 1: channels routed to output 1 (≥1).
- `C_2`, 1: channels routed to output 2 (≥1); ignored when `BROADCAST`=1.
- `DATA_WIDTH`, 32: pixel width.
- `BROADCAST`, 0: 0 = split mode, 1 = duplicate mode.
- Derived: T_1 = D·D·C_1; T_2 = D·D·C_2; frame length F = T_1+T_2 (split) or T_1 (broadcast); counter width = $clog2(F+1).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  `pxl_in` is valid this cycle.
- `pxl_in`  in  DATA_WIDTH  input pixel.
- `pxl_out_1`  out  DATA_WIDTH  branch-1 pixel, registered.
- `valid_out_1`  out  1  branch-1 pixel valid.
- `pxl_out_2`  out  DATA_WIDTH  branch-2 pixel, registered.
- `valid_out_2`  out  1  branch-2 pixel valid.
- `frame_done`  out  1  one-cycle pulse coincident with the last output pixel of a frame.

## Operation
- No backpressure: every `valid_in` pixel is accepted and must be emitted.
- Split mode uses a two-state FSM, S_B1 → S_B2 → S_B1, plus a pixel counter `cnt` that counts accepted pixels within the current phase.
  - S_B1 (reset state): each valid pixel goes to output 1 and `cnt` increments. On the T_1-th pixel, `cnt` clears and the FSM enters S_B2.
  - S_B2: each valid pixel goes to output 2. On the T_2-th pixel, `cnt` clears, `frame_done` asserts, and the FSM returns to S_B1.
- Broadcast mode has no S_B2. Each valid pixel drives both outputs with identical data and both valids in the same cycle. `cnt` counts to T_1; on the T_1-th pixel, `frame_done` asserts and `cnt` clears.
- Cycles with `valid_in`=0 leave the FSM and `cnt` unchanged, deassert both valids, and hold both `pxl_out_*` at their last routed value.
- A non-selected output's data register is not updated.
- Back-to-back frames: the pixel after a frame's last pixel is routed as pixel 0 of the next frame, with no bubble required.
- `valid_out_1` and `valid_out_2` are never both 1 in split mode.

## Timing
- Latency is exactly 1 cycle: a pixel accepted at edge k appears on its output(s) with valid high after edge k (visible during cycle k+1).
- Throughput: 1 pixel/cycle sustained.
- Reset (`reset`=0, asynchronous) forces:
  - FSM = S_B1, `cnt`=0;
  - `pxl_out_1`=`pxl_out_2`=0;
  - `valid_out_1`=`valid_out_2`=`frame_done`=0.
- Reset asserted mid-frame discards the partial frame. The first valid pixel after release is pixel 0 of a new frame, routed to output 1.
- Release is synchronous-safe: state updates begin on the first rising edge with `reset`=1.
- `frame_done` is high for exactly one cycle, the same cycle as the final output valid (`valid_out_2` in split, both valids in broadcast).
- Phase-boundary transition (T_1-th pixel) takes effect for the very next accepted pixel, even if it arrives on the next cycle.
- `cnt` never exceeds max(T_1,T_2)−1 in a stored state; wrap is an explicit clear, not an overflow.

## Test plan
- Split, D=2, C_1=1, C_2=2, continuous valid, `pxl_in`=0..11 → out1 carries 0..3 (cycles 1–4), out2 carries 4..11 (cycles 5–12), `frame_done` high only in cycle 12; valids never overlap.
- Same config, `valid_in` toggling 1,0,1,0… → same routing and order; valids track input gaps with 1-cycle delay; `pxl_out_*` hold through gaps.
- Two back-to-back frames, 24 continuous pixels → second frame's pixels 12..15 on out1 and 16..23 on out2; `frame_done` pulses in cycles 12 and 24.
- Reset pulse after pixel 6 (mid-S_B2), then resend 0..11 → all outputs 0 during reset; after release, 0..3 go to out1 and 4..11 to out2, with no leftover state.
- Broadcast, D=2, C_1=2, pixels 0..7 → both outputs carry 0..7 with simultaneous valids in cycles 1–8; `frame_done` in cycle 8.
- Boundary, D=1, C_1=1, C_2=1, pixels A,B → A on out1 in cycle 1; B on out2 in cycle 2 with `frame_done`; next pixel C goes to out1.

Source files
------------

// File: rtl/split_2o.sv
// Channel-wise stream splitter: the first T_1 pixels of each frame go to output 1, the
// remaining T_2 pixels go to output 2. Broadcast mode duplicates every pixel to both outputs.
module split_2o #(
    parameter int D          = 220,
    parameter int C_1        = 1,
    parameter int C_2        = 1,
    parameter int DATA_WIDTH = 32,
    parameter int BROADCAST  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out_1,
    output logic                  valid_out_1,
    output logic [DATA_WIDTH-1:0] pxl_out_2,
    output logic                  valid_out_2,
    output logic                  frame_done,
    output logic                  o_dbg_state
);

    localparam int T_1 = D * D * C_1;
    localparam int T_2 = D * D * C_2;
    localparam bit BC  = (BROADCAST != 0);
    localparam int F   = BC ? T_1 : (T_1 + T_2);
    localparam int CW  = $clog2(F + 1);

    localparam logic [CW-1:0] LAST1 = CW'(T_1 - 1);
    localparam logic [CW-1:0] LAST2 = CW'(T_2 - 1);

    typedef enum logic {
        S_B1 = 1'b0,
        S_B2 = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_sel1;
    logic            w_sel2;
    logic            w_done;

    // Valid-only stream, no ready: a pixel is transferred on every rising edge where
    // valid_in is 1, and each output valid is high for exactly the one cycle its pixel is shown.

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_B1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (valid_in) begin
            case (r_state)
                S_B1: begin
                    if (r_cnt == LAST1) begin
                        w_cnt_nxt = '0;
                        if (!BC) w_state_nxt = S_B2;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_B2: begin
                    if (r_cnt == LAST2) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_B1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_B1;
                end
            endcase
        end
    end

    always_comb begin
        w_sel1 = 1'b0;
        w_sel2 = 1'b0;
        w_done = 1'b0;
        if (valid_in) begin
            if (BC) begin
                w_sel1 = 1'b1;
                w_sel2 = 1'b1;
                w_done = (r_cnt == LAST1);
            end else begin
                w_sel1 = (r_state == S_B1);
                w_sel2 = (r_state == S_B2);
                w_done = (r_state == S_B2) && (r_cnt == LAST2);
            end
        end
    end

    // Data registers only load when their branch is selected, so they hold through gaps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_out_1   <= '0;
            pxl_out_2   <= '0;
            valid_out_1 <= 1'b0;
            valid_out_2 <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            valid_out_1 <= w_sel1;
            valid_out_2 <= w_sel2;
            frame_done  <= w_done;
            if (w_sel1) pxl_out_1 <= pxl_in;
            if (w_sel2) pxl_out_2 <= pxl_in;
        end
    end

    assign o_dbg_state = r_state;

endmodule
